// File: rtl/rate_scheduler_if.sv
// Control and strobe bundle for rate_scheduler; the scheduler is the slave side.
// Signal names follow the block's external port list.
interface rate_scheduler_if #(
  parameter int CW = 10
) ();
  logic          ce_in;
  logic          run;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_top0;
  logic [CW-1:0] cfg_top1;
  logic [CW-1:0] cfg_top2;
  logic          ce_out0;
  logic          ce_out1;
  logic          ce_out2;
  logic          frame;
  logic          busy;

  modport master (
    output ce_in, run, cfg_valid, cfg_top0, cfg_top1, cfg_top2,
    input  cfg_ready, ce_out0, ce_out1, ce_out2, frame, busy
  );

  modport slave (
    input  ce_in, run, cfg_valid, cfg_top0, cfg_top1, cfg_top2,
    output cfg_ready, ce_out0, ce_out1, ce_out2, frame, busy
  );
endinterface

// File: rtl/rate_scheduler.sv
// Three cascaded clock-enable dividers with frame-aligned reconfiguration.
// Strobes are registered (1-cycle latency); a new divide set waits in shadows until the frame.
module rate_scheduler #(
  parameter int CW        = 10,
  parameter int TOP0_INIT = 9,
  parameter int TOP1_INIT = 4,
  parameter int TOP2_INIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  rate_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [2:0][CW-1:0] INIT = {CW'(TOP2_INIT), CW'(TOP1_INIT), CW'(TOP0_INIT)};

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_pend;
  logic [2:0][CW-1:0]   r_cnt;
  logic [2:0][CW-1:0]   r_top;
  logic [2:0][CW-1:0]   r_shadow;
  logic [2:0]           r_ce;
  logic                 r_frame;

  logic [2:0][CW-1:0]   w_cfg;
  logic [2:0]           w_strb;
  logic [2:0]           w_tick;
  logic                 w_active;
  logic                 w_ready;
  logic                 w_hs;

  assign w_cfg    = {bus.cfg_top2, bus.cfg_top1, bus.cfg_top0};
  assign w_active = (r_state != IDLE);
  // Only registers feed cfg_ready, so an upstream source may depend on it combinationally.
  assign w_ready  = (r_state == IDLE) || !r_pend;
  assign w_hs     = bus.cfg_valid && w_ready;

  always_comb begin
    w_strb      = '0;
    w_tick      = '0;
    w_state_nxt = r_state;

    w_strb[0] = bus.ce_in;
    w_tick[0] = w_active && w_strb[0] && (r_cnt[0] == '0);
    w_strb[1] = w_tick[0];
    w_tick[1] = w_active && w_strb[1] && (r_cnt[1] == '0);
    w_strb[2] = w_tick[1];
    w_tick[2] = w_active && w_strb[2] && (r_cnt[2] == '0);

    case (r_state)
      IDLE: if (bus.run) w_state_nxt = RUN;
      RUN:  if (!bus.run) w_state_nxt = STOP;
      STOP: begin
        if (bus.run)        w_state_nxt = RUN;
        else if (w_tick[2]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend   <= 1'b0;
      r_top    <= INIT;
      r_cnt    <= INIT;
      r_shadow <= '0;
      r_ce     <= '0;
      r_frame  <= 1'b0;
    end else begin
      r_ce    <= w_tick;
      r_frame <= w_tick[2];
      if (r_state == IDLE) begin
        if (w_hs) begin
          r_top <= w_cfg;
          r_cnt <= w_cfg;
        end else begin
          r_cnt <= r_top;
        end
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (w_strb[k]) r_cnt[k] <= w_tick[k] ? r_top[k] : r_cnt[k] - CW'(1);
        end
        // A handshake needs pend clear and an apply needs pend set, so they never collide;
        // a set captured on a frame tick therefore waits for the next frame.
        if (w_hs) begin
          r_shadow <= w_cfg;
          r_pend   <= 1'b1;
        end
        if (w_tick[2] && r_pend) begin
          r_top  <= r_shadow;
          r_cnt  <= r_shadow;
          r_pend <= 1'b0;
        end
      end
    end
  end

  assign bus.ce_out0   = r_ce[0];
  assign bus.ce_out1   = r_ce[1];
  assign bus.ce_out2   = r_ce[2];
  assign bus.frame     = r_frame;
  assign bus.busy      = w_active;
  assign bus.cfg_ready = w_ready;

endmodule
